cmd_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the SD command path. It shares the single command controller between requester 0 (host register interface) and requester 1 (data-transfer engine, e.g. CMD12/CMD13). For each granted request it latches the index and argument, issues a one-cycle `new_command`, and enforces a cycle-count timeout. It then returns the response and status to the owning requester. It sits between the host/data blocks and the command controller.

---
 rtl/cmd_arbiter.sv | 142 ++++++++++++++
 tb/tb_cmd_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - two-requester round-robin arbiter and sequencer for the SD command path
// Grants the command controller to one requester, issues the command, times it out and returns status.
module cmd_arbiter (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_req0,
    input  logic         i_req1,
    input  logic [5:0]   i_idx0,
    input  logic [5:0]   i_idx1,
    input  logic [31:0]  i_arg0,
    input  logic [31:0]  i_arg1,
    input  logic [31:0]  i_timeout_limit,
    output logic         o_grant0,
    output logic         o_grant1,
    output logic         o_done0,
    output logic         o_done1,
    output logic         o_err_timeout,
    output logic         o_err_index,
    output logic [127:0] o_resp_out,
    output logic         o_ctl_new_command,
    output logic [5:0]   o_ctl_cmd_index,
    output logic [31:0]  o_ctl_cmd_argument,
    input  logic         i_ctl_busy,
    input  logic         i_ctl_command_complete,
    input  logic         i_ctl_command_index_error,
    input  logic [127:0] i_ctl_response
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_last_grant;
    logic [31:0]    r_timer;
    logic           r_grant0;
    logic           r_grant1;
    logic           r_done0;
    logic           r_done1;
    logic           r_err_timeout;
    logic           r_err_index;
    logic [127:0]   r_resp;
    logic           r_new_command;
    logic [5:0]     r_cmd_index;
    logic [31:0]    r_cmd_argument;

    logic           w_any_req;
    logic           w_pick;
    logic           w_timeout_hit;

    // On a tie the requester that did not own the last command wins.
    assign w_any_req = i_req0 | i_req1;
    assign w_pick    = (i_req0 && i_req1) ? ~r_last_grant : i_req1;

    // The timer holds the number of WAIT cycles already completed, so a timeout
    // spends timeout_limit+1 WAIT cycles and done lands timeout_limit+2 cycles after new_command.
    assign w_timeout_hit = (i_timeout_limit != 32'd0) && (r_timer == i_timeout_limit);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_owner        <= 1'b0;
            r_last_grant   <= 1'b1;
            r_timer        <= 32'd0;
            r_grant0       <= 1'b0;
            r_grant1       <= 1'b0;
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_err_index    <= 1'b0;
            r_resp         <= 128'd0;
            r_new_command  <= 1'b0;
            r_cmd_index    <= 6'd0;
            r_cmd_argument <= 32'd0;
        end else begin
            r_new_command <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!i_ctl_busy && w_any_req) begin
                        r_owner        <= w_pick;
                        r_cmd_index    <= w_pick ? i_idx1 : i_idx0;
                        r_cmd_argument <= w_pick ? i_arg1 : i_arg0;
                        r_grant0       <= ~w_pick;
                        r_grant1       <= w_pick;
                        r_new_command  <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= 32'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_timer != 32'hFFFF_FFFF) begin
                        r_timer <= r_timer + 32'd1;
                    end
                    if (i_ctl_command_complete) begin
                        r_resp        <= i_ctl_response;
                        r_err_index   <= i_ctl_command_index_error;
                        r_err_timeout <= 1'b0;
                        r_done0       <= ~r_owner;
                        r_done1       <= r_owner;
                        r_state       <= S_DONE;
                    end else if (w_timeout_hit) begin
                        r_err_index   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_done0       <= ~r_owner;
                        r_done1       <= r_owner;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                    r_grant0     <= 1'b0;
                    r_grant1     <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant0           = r_grant0;
    assign o_grant1           = r_grant1;
    assign o_done0            = r_done0;
    assign o_done1            = r_done1;
    assign o_err_timeout      = r_err_timeout;
    assign o_err_index        = r_err_index;
    assign o_resp_out         = r_resp;
    assign o_ctl_new_command  = r_new_command;
    assign o_ctl_cmd_index    = r_cmd_index;
    assign o_ctl_cmd_argument = r_cmd_argument;

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb/tb_cmd_arbiter.sv - self-checking bench for cmd_arbiter
// Acts as the command controller and predicts owner, timing, errors and response per command.
module tb_cmd_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         i_req0, i_req1;
    logic [5:0]   i_idx0, i_idx1;
    logic [31:0]  i_arg0, i_arg1, i_timeout_limit;
    logic         o_grant0, o_grant1, o_done0, o_done1, o_err_timeout, o_err_index;
    logic [127:0] o_resp_out;
    logic         o_ctl_new_command;
    logic [5:0]   o_ctl_cmd_index;
    logic [31:0]  o_ctl_cmd_argument;
    logic         i_ctl_busy, i_ctl_command_complete, i_ctl_command_index_error;
    logic [127:0] i_ctl_response;

    int           checks = 0;
    int           failures = 0;
    int           last_owner = 1;
    logic [127:0] exp_resp = '0;

    cmd_arbiter dut (
        .clock                     (clock),
        .reset                     (reset),
        .i_req0                    (i_req0),
        .i_req1                    (i_req1),
        .i_idx0                    (i_idx0),
        .i_idx1                    (i_idx1),
        .i_arg0                    (i_arg0),
        .i_arg1                    (i_arg1),
        .i_timeout_limit           (i_timeout_limit),
        .o_grant0                  (o_grant0),
        .o_grant1                  (o_grant1),
        .o_done0                   (o_done0),
        .o_done1                   (o_done1),
        .o_err_timeout             (o_err_timeout),
        .o_err_index               (o_err_index),
        .o_resp_out                (o_resp_out),
        .o_ctl_new_command         (o_ctl_new_command),
        .o_ctl_cmd_index           (o_ctl_cmd_index),
        .o_ctl_cmd_argument        (o_ctl_cmd_argument),
        .i_ctl_busy                (i_ctl_busy),
        .i_ctl_command_complete    (i_ctl_command_complete),
        .i_ctl_command_index_error (i_ctl_command_index_error),
        .i_ctl_response            (i_ctl_response)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        i_ctl_command_complete = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        last_owner = 1;
        exp_resp = '0;
    endtask

    // Called at an IDLE-cycle negedge with requests already set; returns at the IDLE negedge after DONE.
    // d = WAIT cycle (1-based) in which the controller reports completion.
    task automatic do_cmd(input string tag, input int d, input bit ierr, input logic [127:0] rsp);
        int          owner, exp_c, done_c, pulses, wait_n;
        longint      lim;
        bit          exp_to, overlap, idx_bad, got;
        logic [5:0]  eidx;
        logic [31:0] earg;
        owner  = (i_req0 && i_req1) ? (last_owner == 0 ? 1 : 0) : (i_req0 ? 0 : 1);
        eidx   = owner ? i_idx1 : i_idx0;
        earg   = owner ? i_arg1 : i_arg0;
        lim    = longint'(i_timeout_limit);
        exp_to = (lim != 0) && (longint'(d) > lim + 1);
        exp_c  = exp_to ? int'(lim + 2) : d + 1;
        got    = 1'b0;
        wait_n = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            wait_n++;
            got = o_ctl_new_command;
        end
        chk({tag, "_issue"}, got, 1'b1);
        if (!got) return;
        chk({tag, "_issue_latency"}, wait_n, 1);
        chk({tag, "_grant"}, {o_grant1, o_grant0}, owner ? 2'b10 : 2'b01);
        chk({tag, "_index"}, o_ctl_cmd_index, eidx);
        chk({tag, "_arg"}, o_ctl_cmd_argument, earg);
        pulses = 1; overlap = 0; idx_bad = 0; done_c = -1;
        for (int k = 1; k < 3000 && done_c < 0; k++) begin
            @(negedge clock);
            if (o_ctl_new_command) pulses++;
            if (o_grant0 && o_grant1) overlap = 1;
            if (o_ctl_cmd_index !== eidx || o_ctl_cmd_argument !== earg) idx_bad = 1;
            if (o_done0 || o_done1) begin
                done_c = k;
                i_ctl_command_complete = 1'b0;
                i_ctl_command_index_error = 1'b0;
            end else begin
                i_ctl_command_complete    = (k == d);
                i_ctl_command_index_error = (k == d) && ierr;
                i_ctl_response            = (k == d) ? rsp : {$urandom, $urandom, $urandom, $urandom};
            end
        end
        i_ctl_command_complete = 1'b0;
        if (!exp_to) exp_resp = rsp;
        chk({tag, "_done_cycle"}, done_c, exp_c);
        chk({tag, "_done_owner"}, {o_done1, o_done0}, owner ? 2'b10 : 2'b01);
        chk({tag, "_grant_at_done"}, {o_grant1, o_grant0}, owner ? 2'b10 : 2'b01);
        chk({tag, "_err_timeout"}, o_err_timeout, exp_to);
        chk({tag, "_err_index"}, o_err_index, exp_to ? 1'b0 : ierr);
        chk({tag, "_resp"}, o_resp_out, exp_resp);
        chk({tag, "_single_pulse"}, pulses, 1);
        chk({tag, "_no_overlap"}, overlap, 1'b0);
        chk({tag, "_latch_stable"}, idx_bad, 1'b0);
        last_owner = owner;
        @(negedge clock);
        chk({tag, "_idle_grant"}, {o_grant1, o_grant0, o_done1, o_done0}, 4'b0);
        chk({tag, "_err_hold"}, {o_err_timeout, o_err_index}, {exp_to, exp_to ? 1'b0 : ierr});
    endtask

    initial begin
        bit busy_grant;
        bit seen;
        reset = 1'b1;
        i_req0 = 0; i_req1 = 0; i_idx0 = 0; i_idx1 = 0; i_arg0 = 0; i_arg1 = 0;
        i_timeout_limit = 0; i_ctl_busy = 0; i_ctl_command_complete = 0;
        i_ctl_command_index_error = 0; i_ctl_response = 0;
        repeat (3) @(negedge clock);
        chk("reset_flags", {o_grant0, o_grant1, o_done0, o_done1, o_err_timeout, o_err_index, o_ctl_new_command}, 7'b0);
        chk("reset_resp", o_resp_out, 128'd0);
        chk("reset_index", o_ctl_cmd_index, 6'd0);
        chk("reset_arg", o_ctl_cmd_argument, 32'd0);
        reset = 1'b0;

        // Single request
        i_req0 = 1; i_idx0 = 6'd17; i_arg0 = 32'h0000_0200; i_idx1 = 6'd9; i_arg1 = 32'hDEAD_0001;
        do_cmd("single", 5, 1'b0, 128'hA5);
        i_req0 = 0;

        // Ties after reset: owners 0, 1, 0
        do_reset();
        i_req0 = 1; i_req1 = 1;
        do_cmd("tie_a", 2, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        chk("tie_a_owner", last_owner, 0);
        do_cmd("tie_b", 3, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        chk("tie_b_owner", last_owner, 1);
        do_cmd("tie_c", 1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        chk("tie_c_owner", last_owner, 0);
        i_req1 = 0;

        // Timeout, then disabled timeout with a slow completion
        i_timeout_limit = 8;
        do_cmd("timeout8", 100000, 1'b0, 128'h1);
        i_timeout_limit = 0;
        do_cmd("no_timeout", 1000, 1'b0, 128'h1234_5678);
        i_req0 = 0;

        // Index error and completion on the timeout cycle
        i_req1 = 1; i_timeout_limit = 20;
        do_cmd("index_err", 3, 1'b1, 128'hBEEF);
        i_req1 = 0; i_req0 = 1; i_timeout_limit = 4;
        do_cmd("complete_at_limit", 5, 1'b0, 128'hC0DE);
        i_req0 = 0; i_timeout_limit = 0;

        // Busy gating
        i_ctl_busy = 1; i_req1 = 1; busy_grant = 0;
        repeat (6) begin
            @(negedge clock);
            if (o_grant0 || o_grant1 || o_ctl_new_command) busy_grant = 1;
        end
        chk("busy_no_grant", busy_grant, 1'b0);
        i_ctl_busy = 0;
        do_cmd("after_busy", 2, 1'b0, {$urandom, $urandom, $urandom, $urandom});

        // Reset while waiting, then a tie goes to requester 0
        i_req0 = 1; i_req1 = 1; seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = o_ctl_new_command;
        end
        chk("rst_wait_issue", seen, 1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_wait_flags", {o_grant0, o_grant1, o_done0, o_done1, o_err_timeout, o_err_index, o_ctl_new_command}, 7'b0);
        chk("rst_wait_resp", o_resp_out, 128'd0);
        chk("rst_wait_index", o_ctl_cmd_index, 6'd0);
        reset = 1'b0; last_owner = 1; exp_resp = '0;
        do_cmd("rst_tie", 2, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        chk("rst_tie_owner", last_owner, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 25; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            i_req0 = pat[0]; i_req1 = pat[1];
            i_idx0 = 6'($urandom); i_idx1 = 6'($urandom);
            i_arg0 = $urandom; i_arg1 = $urandom;
            i_timeout_limit = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 10));
            do_cmd($sformatf("rand%0d", n), $urandom_range(1, 14), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom, $urandom, $urandom});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
